// File: rtl/crc32_check.sv
// crc32_check -- word-oriented CRC-32 frame checker, one bit per clock.
//
// Each payload word is shifted MSB-first through the CRC register over 32
// cycles. The word flagged with last_i carries the received CRC; one cycle
// after it is accepted the block pulses done_o and reports the computed CRC
// and whether it matches. The result is held until the next report or clear.
//
// Ports
//   clk_i    in   1  clock, rising edge
//   rst_i    in   1  asynchronous reset, active low
//   data_i   in  32  payload word, or received CRC when last_i=1
//   valid_i  in   1  data_i/last_i valid
//   last_i   in   1  current word is the received CRC and closes the frame
//   clear_i  in   1  synchronous abort of the current frame
//   ready_o  out  1  a word can be accepted this cycle (registered)
//   done_o   out  1  one-cycle pulse, check result valid
//   match_o  out  1  received CRC equals computed CRC
//   crc_o    out 32  computed final CRC of the last frame
//
// state  | meaning
// IDLE   | waiting for a word, ready_o=1
// SHIFT  | consuming the latched payload word, one bit per cycle
// REPORT | comparing the received CRC, done_o pulse

module crc32_check #(
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        last_i,
  input  logic        clear_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        match_o,
  output logic [31:0] crc_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        match_q, match_d;
  logic [31:0] crc_out_q, crc_out_d;

  logic        accept;
  logic        report;
  logic        fb;
  logic [31:0] crc_final;
  logic        crc_equal;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    crc_out_d = crc_out_q;

    accept    = valid_i & ready_q & ~clear_i;
    report    = (state_q == REPORT) & ~clear_i;
    crc_final = crc_q ^ XOROUT;
    // In REPORT the shift register holds the received CRC word.
    crc_equal = (sr_q == crc_final);
    fb        = crc_q[31] ^ sr_q[31];

    if (clear_i) begin
      state_d   = IDLE;
      crc_d     = INIT;
      sr_d      = '0;
      cnt_d     = '0;
      match_d   = 1'b0;
      crc_out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sr_d    = data_i;
            cnt_d   = '0;
            state_d = last_i ? REPORT : SHIFT;
          end
        end
        SHIFT: begin
          crc_d = {crc_q[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
          sr_d  = {sr_q[30:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = IDLE;
          end
        end
        REPORT: begin
          match_d   = crc_equal;
          crc_out_d = crc_final;
          crc_d     = INIT;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      sr_q      <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      match_q   <= 1'b0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      match_q   <= match_d;
      crc_out_q <= crc_out_d;
    end
  end

  // The result is visible during the REPORT cycle itself and held afterwards.
  assign ready_o = ready_q;
  assign done_o  = report;
  assign match_o = report ? crc_equal : match_q;
  assign crc_o   = report ? crc_final : crc_out_q;

endmodule

// File: tb/tb_crc32_check.sv
module tb_crc32_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        last = 1'b0;
  logic        clear = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;

  logic        ready_a, done_a, match_a;
  logic [31:0] crc_a;
  logic        ready_b, done_b, match_b;
  logic [31:0] crc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default parameters
  crc32_check dut_a (
    .clk_i(clk), .rst_i(rst_n), .data_i(data), .valid_i(valid_a),
    .last_i(last), .clear_i(clear), .ready_o(ready_a), .done_o(done_a),
    .match_o(match_a), .crc_o(crc_a)
  );

  // Plain polynomial remainder: INIT=0, XOROUT=0
  crc32_check #(.INIT(32'h0), .XOROUT(32'h0)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .data_i(data), .valid_i(valid_b),
    .last_i(last), .clear_i(clear), .ready_o(ready_b), .done_o(done_b),
    .match_o(match_b), .crc_o(crc_b)
  );

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        match;
    logic [31:0] crc;
  } outs_t;

  typedef struct {
    bit          sel;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] crcw;
    logic [31:0] exp_crc;
    bit          exp_match;
  } vec_t;

  vec_t vecs[10];

  function automatic outs_t get_outs(input bit sel);
    outs_t o;
    if (sel) o = '{ready_b, done_b, match_b, crc_b};
    else     o = '{ready_a, done_a, match_a, crc_a};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_word(input bit sel, input logic [31:0] d, input bit lst, output bit ok);
    outs_t o;
    int n;
    ok = 1'b0;
    n = 0;
    @(negedge clk);
    o = get_outs(sel);
    while (!o.ready && n < 200) begin
      @(negedge clk);
      n++;
      o = get_outs(sel);
    end
    if (!o.ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    data = d;
    last = lst;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    last = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_frame(input bit sel, input int nw, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] crcw,
                           input logic [31:0] exp_crc, input bit exp_match);
    outs_t o;
    bit ok;
    int cnt;
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? w0 : w1;
      send_word(sel, w, 1'b0, ok);
      if (ok) begin
        cnt = 0;
        o = get_outs(sel);
        while (!o.ready && cnt < 100) begin
          @(posedge clk);
          #1;
          cnt++;
          o = get_outs(sel);
        end
        chk("ready_low_cycles", cnt, 32);
      end
    end
    send_word(sel, crcw, 1'b1, ok);
    if (ok) begin
      o = get_outs(sel);
      chk("report_done", {31'd0, o.done}, 32'd1);
      chk("report_ready", {31'd0, o.ready}, 32'd0);
      chk("report_crc", o.crc, exp_crc);
      chk("report_match", {31'd0, o.match}, {31'd0, exp_match});
      @(posedge clk);
      #1;
      o = get_outs(sel);
      chk("after_done", {31'd0, o.done}, 32'd0);
      chk("after_ready", {31'd0, o.ready}, 32'd1);
      chk("held_crc", o.crc, exp_crc);
      chk("held_match", {31'd0, o.match}, {31'd0, exp_match});
    end
  endtask

  initial begin
    outs_t o;
    bit ok;
    int pulses;

    vecs[0] = '{0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vecs[1] = '{0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{0, 0, 32'h0,        32'h0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{1, 2, 32'h00000000, 32'h1, 32'h04C11DB7, 32'h04C11DB7, 1'b1};
    vecs[4] = '{1, 1, 32'h00000001, 32'h0, 32'h04C11DB7, 32'h04C11DB7, 1'b1};
    vecs[5] = '{1, 0, 32'h0,        32'h0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[6] = '{1, 1, 32'h00000002, 32'h0, 32'h09823B6E, 32'h09823B6E, 1'b1};
    vecs[7] = '{1, 1, 32'h00000003, 32'h0, 32'h00000000, 32'h0D4326D9, 1'b0};
    vecs[8] = '{1, 1, 32'h00000004, 32'h0, 32'h130476DC, 32'h130476DC, 1'b1};
    vecs[9] = '{1, 0, 32'h0,        32'h0, 32'h00000001, 32'h00000000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_outs", {ready_a, done_a, match_a, crc_a}, 35'd0);
    chk("rst_b_outs", {ready_b, done_b, match_b, crc_b}, 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready_a", {31'd0, ready_a}, 32'd1);
    chk("rst_release_ready_b", {31'd0, ready_b}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].sel, vecs[i].nw, vecs[i].w0, vecs[i].w1,
                vecs[i].crcw, vecs[i].exp_crc, vecs[i].exp_match);
    end

    // Clear during the REPORT cycle suppresses done and zeroes the result
    run_frame(0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    send_word(0, 32'h0, 1'b1, ok);
    clear = 1'b1;
    #1;
    chk("clr_report_done_comb", {31'd0, done_a}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    o = get_outs(0);
    chk("clr_report_outs", {o.ready, o.done, o.match, o.crc}, {1'b1, 34'd0});

    // Clear in the middle of SHIFT aborts the frame
    run_frame(0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    send_word(0, 32'hFFFFFFFF, 1'b0, ok);
    repeat (9) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    o = get_outs(0);
    chk("clr_shift_outs", {o.ready, o.done, o.match, o.crc}, {1'b1, 34'd0});
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    chk("clr_shift_no_done", pulses, 0);
    run_frame(0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    // Asynchronous reset in the middle of SHIFT
    send_word(0, 32'hFFFFFFFF, 1'b0, ok);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    o = get_outs(0);
    chk("rst_shift_outs", {o.ready, o.done, o.match, o.crc}, 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_shift_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_shift_done", {31'd0, done_a}, 32'd0);
    run_frame(0, 1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
